player_input_conditioner: RTL and testbench
===========================================

PLAYER_INPUT_CONDITIONER -- requirements
Module: player_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_WIDTH, default 16, width of each debounce counter.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000, consecutive synchronized samples needed to accept a level change; legal range 1 to 2^DEBOUNCE_WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_up_raw  input  1  asynchronous up/jump pushbutton, high = pressed.
REQ-006 SHALL have port btn_down_raw  input  1  asynchronous down/duck pushbutton, high = pressed.
REQ-007 SHALL have port game_tick  input  2  game tick enables; only bit 0 is used, bit 1 is ignored.
REQ-008 SHALL have port button_up  output  1  conditioned up request for the player controller.
REQ-009 SHALL have port button_down  output  1  conditioned down level for the player controller.

Function
REQ-010 SHALL pass each raw button through its own 2-flop synchronizer (sync1, sync2).
REQ-011 SHALL keep a per-button debounce FSM with states RELEASED and PRESSED, plus a DEBOUNCE_WIDTH-bit counter.
REQ-012 Counter SHALL increment each cycle sync2 differs from the FSM level and SHALL clear to 0 any cycle they match.
REQ-013 FSM SHALL toggle state and clear the counter on the edge where sync2 differs and counter == DEBOUNCE_CYCLES-1.
REQ-014 Raw level held stable from before edge 0 SHALL change the debounced level after edge DEBOUNCE_CYCLES+1.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave the FSM state unchanged.
REQ-016 Counter SHALL never wrap; it cannot exceed DEBOUNCE_CYCLES-1.
REQ-017 button_down SHALL equal (down FSM == PRESSED), registered, no extra latency.
REQ-018 SHALL hold up_pending: set on the edge where up FSM enters PRESSED; cleared on any edge with game_tick[0]=1; clear wins if both occur on the same edge.
REQ-019 button_up SHALL equal (up FSM == PRESSED) OR up_pending, so a press released before the next game_tick[0] is still seen for exactly one tick.
REQ-020 A press spanning several game_tick[0] pulses SHALL keep button_up high for the whole debounced press.
REQ-021 Both buttons SHALL be conditioned independently; simultaneous presses SHALL be reported on both outputs except as REQ-026 states.

Reset
REQ-022 Reset assertion SHALL asynchronously clear sync flops, counters and up_pending and force both FSMs to RELEASED.
REQ-023 button_up and button_down SHALL be 0 during and immediately after reset.
REQ-024 Reset asserted mid-debounce or with up_pending set SHALL discard the partial count and pending press; a held button is re-accepted after DEBOUNCE_CYCLES+1 edges from reset release.

Configuration
REQ-025 Macro PLAYER_INPUT_LOCKOUT_EN SHALL select up/down lockout at compile time.
REQ-026 With PLAYER_INPUT_LOCKOUT_EN defined: button_up SHALL be forced 0 while down FSM == PRESSED, and up_pending SHALL be cleared on any edge where down FSM == PRESSED.
REQ-027 Without PLAYER_INPUT_LOCKOUT_EN: no lockout; outputs follow REQ-017 to REQ-021 only.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset released, btn_up_raw 0->1 before edge 0 and held, game_tick=0 -> button_up 0 through edge 4, 1 after edge 5.
REQ-029 btn_up_raw high for 3 cycles then low -> button_up stays 0 throughout.
REQ-030 btn_up_raw high 6 cycles then low, no tick -> button_up stays 1 after release; first game_tick[0]=1 edge -> 0 on next cycle.
REQ-031 Reset pulsed mid-count (counter=2) with btn_down_raw held high -> button_down 0, goes 1 after edge 5 post-release.
REQ-032 Both buttons held debounced -> with PLAYER_INPUT_LOCKOUT_EN: button_up=0, button_down=1; without: both 1.
REQ-033 Up FSM enters PRESSED on the same edge as game_tick[0]=1 with raw released next cycle -> up_pending stays 0, button_up drops once FSM returns to RELEASED.

Source files
------------

// File: rtl/player_input_conditioner.sv
// player_input_conditioner
//   Conditions the two raw player pushbuttons (up/jump, down/duck) for the
//   player controller. Each button passes through a 2-flop synchronizer and a
//   RELEASED/PRESSED debounce FSM with a saturating-free run counter. A short
//   debounced up press is latched in up_pending so that the controller, which
//   only looks at the button on game_tick[0], cannot miss it.
//
//   Compile-time option:
//     PLAYER_INPUT_LOCKOUT_EN - when defined, a held (debounced) down button
//                               suppresses button_up and discards any
//                               pending up press.
module player_input_conditioner #(
    parameter int DEBOUNCE_WIDTH  = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic [1:0] game_tick,
    output logic       button_up,
    output logic       button_down
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } db_state_t;

    // Index of each button in the per-button arrays.
    localparam int BTN_UP = 0;
    localparam int BTN_DN = 1;

    // Counter value on which a differing sample completes the debounce window.
    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ONE  = DEBOUNCE_WIDTH'(1);
    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ZERO = DEBOUNCE_WIDTH'(0);

    logic [1:0]                raw_s;
    logic [1:0]                sync1_r;
    logic [1:0]                sync2_r;
    db_state_t                 state_r [2];
    db_state_t                 state_n [2];
    logic [DEBOUNCE_WIDTH-1:0] cnt_r   [2];
    logic [DEBOUNCE_WIDTH-1:0] cnt_n   [2];
    logic                      up_pending_r;
    logic                      up_pending_n;
    logic                      up_enter_s;
    logic                      lockout_s;
    logic                      unused_tick_s;

    assign raw_s         = {btn_down_raw, btn_up_raw};
    // Only bit 0 of the tick bus drives this block.
    assign unused_tick_s = game_tick[1];

`ifdef PLAYER_INPUT_LOCKOUT_EN
    assign lockout_s = (state_r[BTN_DN] == PRESSED);
`else
    assign lockout_s = 1'b0;
`endif

    // Two-flop synchronizer for both raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM state and run counter registers for both buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= RELEASED;
                cnt_r[i]   <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= state_n[i];
                cnt_r[i]   <= cnt_n[i];
            end
        end
    end

    // Debounce next state: count consecutive samples that disagree with the
    // accepted level, toggle once the window completes, restart on agreement.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_n[i] = state_r[i];
            cnt_n[i]   = CNT_ZERO;
            case (state_r[i])
                RELEASED: begin
                    if (sync2_r[i]) begin
                        if (cnt_r[i] == CNT_LAST) begin
                            state_n[i] = PRESSED;
                            cnt_n[i]   = CNT_ZERO;
                        end else begin
                            cnt_n[i]   = cnt_r[i] + CNT_ONE;
                        end
                    end else begin
                        cnt_n[i] = CNT_ZERO;
                    end
                end
                PRESSED: begin
                    if (!sync2_r[i]) begin
                        if (cnt_r[i] == CNT_LAST) begin
                            state_n[i] = RELEASED;
                            cnt_n[i]   = CNT_ZERO;
                        end else begin
                            cnt_n[i]   = cnt_r[i] + CNT_ONE;
                        end
                    end else begin
                        cnt_n[i] = CNT_ZERO;
                    end
                end
                default: begin
                    state_n[i] = RELEASED;
                    cnt_n[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    assign up_enter_s = (state_r[BTN_UP] == RELEASED) && (state_n[BTN_UP] == PRESSED);

    // Pending up press: a tick consumes it (and wins over a new press on the
    // same edge); a held down button discards it when lockout is built in.
    always_comb begin
        up_pending_n = up_pending_r;
        if (game_tick[0]) begin
            up_pending_n = 1'b0;
        end else if (lockout_s) begin
            up_pending_n = 1'b0;
        end else if (up_enter_s) begin
            up_pending_n = 1'b1;
        end else begin
            up_pending_n = up_pending_r;
        end
    end

    // Pending up-press register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_pending_r <= 1'b0;
        end else begin
            up_pending_r <= up_pending_n;
        end
    end

    // Outputs are pure functions of flops, so they add no latency or glitches.
    assign button_down = (state_r[BTN_DN] == PRESSED);
    assign button_up   = ((state_r[BTN_UP] == PRESSED) | up_pending_r) & ~lockout_s;

endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner with DEBOUNCE_CYCLES = 4.
// The reference model treats debouncing as a sliding window: the accepted
// level flips when the last DEBOUNCE_CYCLES synchronized samples all disagree
// with it. Directed scenarios add literal expectations on top of the model.
module tb_player_input_conditioner;

    localparam int DW = 16;
    localparam int DB = 4;
`ifdef PLAYER_INPUT_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up_raw;
    logic       btn_down_raw;
    logic [1:0] game_tick;
    logic       button_up;
    logic       button_down;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: 2-sample delay line, sample window, accepted level, pending.
    bit m_d1   [2];
    bit m_d2   [2];
    bit m_hist [2][DB];
    bit m_lvl  [2];
    bit m_pend;

    player_input_conditioner #(
        .DEBOUNCE_WIDTH (DW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .game_tick   (game_tick),
        .button_up   (button_up),
        .button_down (button_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit u, input bit d, input bit t, input bit r);
        bit raw [2];
        bit s2;
        bit all_diff;
        bit old_dn;
        bit rose;
        raw[0] = u;
        raw[1] = d;
        if (r) begin
            for (int b = 0; b < 2; b++) begin
                m_d1[b]  = 1'b0;
                m_d2[b]  = 1'b0;
                m_lvl[b] = 1'b0;
                for (int k = 0; k < DB; k++) m_hist[b][k] = 1'b0;
            end
            m_pend = 1'b0;
        end else begin
            old_dn = m_lvl[1];
            rose   = 1'b0;
            for (int b = 0; b < 2; b++) begin
                s2      = m_d2[b];
                m_d2[b] = m_d1[b];
                m_d1[b] = raw[b];
                for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = s2;
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[b] = ~m_lvl[b];
                    if (b == 0 && m_lvl[0]) rose = 1'b1;
                end
            end
            if (t) m_pend = 1'b0;
            else if (LOCK && old_dn) m_pend = 1'b0;
            else if (rose) m_pend = 1'b1;
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // compare the DUT against the model just after it.
    task automatic cycle(input bit u, input bit d, input bit t, input bit r, input bit t1);
        bit exp_up;
        @(negedge clk);
        btn_up_raw   = u;
        btn_down_raw = d;
        game_tick    = {t1, t};
        reset        = r;
        @(posedge clk);
        model_step(u, d, t, r);
        #1;
        exp_up = (m_lvl[0] | m_pend) & ~(LOCK & m_lvl[1]);
        check("model_up", button_up, exp_up);
        check("model_down", button_down, m_lvl[1]);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    int  hold_u;
    int  hold_d;
    bit  cu;
    bit  cd;

    initial begin
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        game_tick    = 2'b00;

        // Reset state.
        do_reset();
        check("reset_up", button_up, 1'b0);
        check("reset_down", button_down, 1'b0);

        // Held press accepted after edge DB+1.
        for (int k = 0; k <= 6; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("hold_up_latency", button_up, (k >= 5));
        end

        // Glitch of three cycles is rejected.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle((k < 3), 1'b0, 1'b0, 1'b0, 1'b0);
            check("glitch_up", button_up, 1'b0);
        end

        // Short press survives release until the next tick.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cycle((k < 6), 1'b0, 1'b0, 1'b0, 1'b0);
            if (k >= 5) check("pending_hold_up", button_up, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pending_tick_clear", button_up, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pending_stays_clear", button_up, 1'b0);

        // Reset mid-count discards the partial count.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("midcount_reset_down", button_down, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("midcount_reaccept_down", button_down, (k >= 5));
        end

        // Simultaneous presses, with or without lockout.
        do_reset();
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("both_up", button_up, ~LOCK);
        check("both_down", button_down, 1'b1);

        // Press accepted on the same edge as a tick: nothing left pending.
        do_reset();
        for (int k = 0; k <= 5; k++) cycle(1'b1, 1'b0, (k == 5), 1'b0, 1'b0);
        check("tick_race_pressed", button_up, 1'b1);
        for (int k = 6; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 10) check("tick_race_still_held", button_up, 1'b1);
            if (k >= 11) check("tick_race_no_pending", button_up, 1'b0);
        end

        // Randomized button activity, ticks and occasional resets.
        hold_u = 0;
        hold_d = 0;
        cu     = 1'b0;
        cd     = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_u == 0) begin
                cu     = 1'($urandom_range(0, 1));
                hold_u = int'($urandom_range(1, 9));
            end
            if (hold_d == 0) begin
                cd     = 1'($urandom_range(0, 1));
                hold_d = int'($urandom_range(1, 9));
            end
            hold_u--;
            hold_d--;
            cycle(cu, cd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
